ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit: owns the PC, issues one instruction-memory read at a time, and presents each fetched instruction with its PC to the decode stage.
- Valid/ready handshakes on the memory request, memory response and decode output.
- Accepts a redirect (branch/jump target) from execute and discards any in-flight or held wrong-path instruction.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
ADDR_W, 64, PC / fetch address width
INST_W, 32, instruction width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  ADDR_W  fetch address, equals pc
imem_resp_valid  in  1  response valid, single-cycle pulse, always accepted
imem_resp_data  in  INST_W  fetched instruction word
imem_resp_err  in  1  access fault on this response
redirect_valid  in  1  load new PC, flush wrong path
redirect_pc  in  ADDR_W  redirect target
out_valid  out  1  instruction valid to decode
out_ready  in  1  decode accepts instruction
out_pc  out  ADDR_W  PC of presented instruction
out_inst  out  INST_W  instruction word
out_fault  out  1  fetch fault (access error or misaligned PC)

Behaviour:
- Reset: pc=RESET_PC, state=FETCH, drop=0, out_valid=0, out_pc=0, out_inst=0, out_fault=0, imem_req_valid=0 during the reset cycle. The memory side is reset by the same rst; no pre-reset response arrives afterwards.
- States: FETCH, WAIT, HOLD.
- imem_req_valid = (state==FETCH) && !rst && pc[1:0]==0.
- imem_req_addr = pc, held stable while valid and not ready.
- out_valid = (state==HOLD).

FETCH:
- pc[1:0]!=0: no request. Next cycle HOLD with out_pc=pc, out_inst=0, out_fault=1.
- Request handshake (valid && ready): go to WAIT.
- Otherwise: stay in FETCH.

WAIT:
- imem_resp_valid with drop=0: latch out_pc=pc, out_inst=resp_data, out_fault=resp_err, then go to HOLD.
- imem_resp_valid with drop=1: discard the response, clear drop, go to FETCH.

HOLD:
- out_valid && out_ready: pc=pc+4 (wrap modulo 2^ADDR_W), go to FETCH.
- Outputs stay stable until the handshake completes.

Redirect (redirect_valid=1; takes priority over every other event in the same cycle):
- pc=redirect_pc in all states.
- FETCH: any same-cycle request handshake is treated as wrong-path. Go to WAIT with drop=1.
- WAIT: set drop=1, stay in WAIT. If a response arrives in the same cycle, discard it and go to FETCH with drop=0.
- HOLD: the held instruction is discarded even if out_ready=1 (no handshake counted). out_valid=0 next cycle, go to FETCH.

Other rules:
- imem_resp_valid in FETCH or HOLD is ignored (protocol error, no state change).
- Only one outstanding request; no new request while in WAIT or HOLD.
- Timing (no stalls): request cycle N, response N+1, out_valid N+2, next request N+3. Peak throughput is 1 instruction per 3 cycles.
- Fault instructions are passed to decode like normal ones. The PC advances by 4 after a fault handshake unless a redirect occurs.

Test Plan:
- Reset then ready memory (ready=1, 1-cycle response 0x00000013), out_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008, one every 3 cycles; out_pc matches, out_inst=0x00000013.
- Decode stall: out_ready=0 for 5 cycles after out_valid -> out_valid stays 1, out_pc/out_inst stable, no new imem_req_valid; on release next request is at pc+4.
- Redirect in WAIT to 0x80001000, then response 0xDEADBEEF -> response discarded, out_valid never 1 for it, next request at 0x80001000.
- Redirect in HOLD with out_ready=1 in the same cycle, target 0x80000100 -> no handshake counted, out_valid=0 next cycle, next request at 0x80000100.
- Redirect to 0x80000102 -> no imem request, out_valid=1 with out_pc=0x80000102, out_fault=1, out_inst=0. Response with imem_resp_err=1 -> out_fault=1.
- Assert rst while in HOLD with PC 0x8000000C -> next cycle out_valid=0, state FETCH, first request at 0x80000000.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Fetch-unit boundary: instruction-memory request/response, execute redirect and decode output.
// Handshakes: a transfer happens on a cycle where valid && ready are both 1 at the rising edge;
// the sender keeps valid and its payload stable until that cycle. The response has no ready.
interface ifu_fetch_if #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              imem_resp_err;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_fault;
    logic [1:0]        dbg_state;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data, imem_resp_err,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_inst, out_fault,
        input  out_ready,
        output dbg_state
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data, imem_resp_err,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_inst, out_fault,
        output out_ready,
        input  dbg_state
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps one memory read in flight and hands each
// fetched word (or fault) to decode; a redirect reloads the PC and squashes the wrong path.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          ADDR_W   = 64,
    parameter int          INST_W   = 32
) (
    input  logic       clk,
    input  logic       rst,
    ifu_fetch_if.master bus
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              drop;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_fault;
    logic              aligned;
    logic              req_fire;

    assign aligned            = (pc[1:0] == 2'b00);
    assign bus.imem_req_valid = (state == FETCH) && !rst && aligned;
    assign bus.imem_req_addr  = pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    assign bus.out_valid      = (state == HOLD);
    assign bus.out_pc         = out_pc;
    assign bus.out_inst       = out_inst;
    assign bus.out_fault      = out_fault;
    assign bus.dbg_state      = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC[ADDR_W-1:0];
            state     <= FETCH;
            drop      <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
            out_fault <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc <= bus.redirect_pc;
            case (state)
                FETCH: begin
                    // A request accepted this cycle is already wrong-path; wait it out.
                    if (req_fire) begin
                        state <= WAIT;
                        drop  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.imem_resp_valid) begin
                        state <= FETCH;
                        drop  <= 1'b0;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (!aligned) begin
                        state     <= HOLD;
                        out_pc    <= pc;
                        out_inst  <= '0;
                        out_fault <= 1'b1;
                    end else if (req_fire) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= FETCH;
                        end else begin
                            out_pc    <= pc;
                            out_inst  <= bus.imem_resp_data;
                            out_fault <= bus.imem_resp_err;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        pc    <= pc + ADDR_W'(4);
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a transaction-level fetch model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_ifu_fetch;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifu_fetch_if bus ();
    ifu_fetch #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected decode items: {fault, pc, inst}
    logic [96:0] exp_q[$];
    logic [63:0] exp_pc;
    logic        pending;
    logic        wrong;
    logic [63:0] req_pc;
    logic        exp_req;
    logic        hs;
    logic [63:0] req_addr_log[$];
    int          req_cyc_log[$];
    int          ov_cnt = 0;

    logic [31:0] mem_data;
    logic        mem_err;
    int          resp_lat;
    int          mem_cnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output logic [63:0] addr);
        int n;
        n = req_addr_log.size();
        for (int k = 0; k < 50 && req_addr_log.size() == n; k++) tick();
        chk("wait_req_timeout", req_addr_log.size() > n, 1'b1);
        addr = (req_addr_log.size() > n) ? req_addr_log[req_addr_log.size()-1] : 64'hx;
    endtask

    task automatic wait_out();
        for (int k = 0; k < 50 && bus.out_valid !== 1'b1; k++) tick();
        chk("wait_out_timeout", bus.out_valid, 1'b1);
    endtask

    // Memory: answers each accepted request after resp_lat cycles with mem_data/mem_err.
    initial begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.imem_resp_err   = 1'b0;
        mem_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) mem_cnt = 0;
            else if (bus.imem_req_valid && bus.imem_req_ready) mem_cnt = resp_lat;
            @(posedge clk);
            #2;
            bus.imem_resp_valid = 1'b0;
            if (mem_cnt == 1) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem_data;
                bus.imem_resp_err   = mem_err;
            end
            if (mem_cnt > 0) mem_cnt--;
        end
    end

    // Model + compare: one request in flight, one item held for decode, redirect squashes both.
    initial begin
        exp_pc = RST_PC; pending = 0; wrong = 0; req_pc = '0;
        forever begin
            @(negedge clk);
            exp_req = !rst && exp_q.size() == 0 && !pending && exp_pc[1:0] == 2'b00;
            chk("req_valid", bus.imem_req_valid, exp_req);
            if (exp_req) chk("req_addr", bus.imem_req_addr, exp_pc);
            if (!rst) begin
                chk("out_valid", bus.out_valid, exp_q.size() != 0);
                if (exp_q.size() != 0)
                    chk("out_fields", {bus.out_fault, bus.out_pc, bus.out_inst}, exp_q[0]);
                if (bus.out_valid === 1'b1) ov_cnt++;
                if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready) begin
                    req_addr_log.push_back(bus.imem_req_addr);
                    req_cyc_log.push_back(cyc);
                end
            end
            if (rst) begin
                exp_q.delete(); pending = 0; wrong = 0; exp_pc = RST_PC;
            end else begin
                hs = exp_req && bus.imem_req_ready;
                if (bus.redirect_valid) begin
                    exp_pc = bus.redirect_pc;
                    exp_q.delete();
                    if (pending && bus.imem_resp_valid) begin pending = 0; wrong = 0; end
                    else if (pending) wrong = 1;
                    if (hs) begin pending = 1; wrong = 1; end
                end else if (exp_q.size() != 0) begin
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        exp_pc = exp_pc + 64'd4;
                    end
                end else if (pending) begin
                    if (bus.imem_resp_valid) begin
                        pending = 0;
                        if (!wrong) exp_q.push_back({bus.imem_resp_err, req_pc, bus.imem_resp_data});
                        wrong = 0;
                    end
                end else if (exp_pc[1:0] != 2'b00) begin
                    exp_q.push_back({1'b1, exp_pc, 32'h0});
                end else if (hs) begin
                    pending = 1; wrong = 0; req_pc = exp_pc;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] a;
        int n;
        int m;
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        mem_data = 32'h0000_0013; mem_err = 1'b0; resp_lat = 1;
        repeat (3) tick();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_pc", bus.out_pc, 64'h0);
        chk("rst_out_inst", bus.out_inst, 32'h0);
        chk("rst_out_fault", bus.out_fault, 1'b0);
        chk("rst_req_valid", bus.imem_req_valid, 1'b0);
        chk("rst_state", bus.dbg_state, 2'd0);

        // Streaming fetch, no stalls
        rst = 1'b0; bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1;
        for (int k = 0; k < 30 && req_addr_log.size() < 3; k++) tick();
        chk("stream_count", req_addr_log.size() >= 3, 1'b1);
        if (req_addr_log.size() >= 3) begin
            chk("stream_addr0", req_addr_log[0], 64'h8000_0000);
            chk("stream_addr1", req_addr_log[1], 64'h8000_0004);
            chk("stream_addr2", req_addr_log[2], 64'h8000_0008);
            chk("stream_gap01", req_cyc_log[1] - req_cyc_log[0], 3);
            chk("stream_gap12", req_cyc_log[2] - req_cyc_log[1], 3);
        end

        // Decode stall
        bus.out_ready = 1'b0;
        wait_out();
        chk("stall_pc", bus.out_pc, 64'h8000_0008);
        chk("stall_inst", bus.out_inst, 32'h0000_0013);
        n = req_addr_log.size();
        repeat (5) tick();
        chk("stall_valid", bus.out_valid, 1'b1);
        chk("stall_pc_stable", bus.out_pc, 64'h8000_0008);
        chk("stall_no_req", req_addr_log.size(), n);
        bus.out_ready = 1'b1;
        wait_req(a);
        chk("stall_next_addr", a, 64'h8000_000C);

        // Redirect in WAIT, late response discarded
        resp_lat = 3; mem_data = 32'hDEAD_BEEF;
        wait_req(a);
        chk("wait_req_addr", a, 64'h8000_0010);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_1000;
        tick();
        bus.redirect_valid = 1'b0;
        m = ov_cnt;
        wait_req(a);
        chk("wait_redir_addr", a, 64'h8000_1000);
        chk("wait_dropped_no_out", ov_cnt, m);
        mem_data = 32'h0000_0013; resp_lat = 1;

        // Redirect in WAIT on the same cycle as the response
        wait_req(a);
        chk("wait2_req_addr", a, 64'h8000_1004);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_2000;
        tick();
        bus.redirect_valid = 1'b0;
        m = ov_cnt;
        wait_req(a);
        chk("wait2_redir_addr", a, 64'h8000_2000);
        chk("wait2_dropped_no_out", ov_cnt, m);

        // Redirect in FETCH on a handshake cycle
        for (int k = 0; k < 20 && bus.imem_req_valid !== 1'b1; k++) tick();
        chk("fetch_req_seen", bus.imem_req_valid, 1'b1);
        mem_data = 32'hDEAD_BEEF;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_3000;
        tick();
        bus.redirect_valid = 1'b0;
        m = ov_cnt;
        wait_req(a);
        mem_data = 32'h0000_0013;
        chk("fetch_redir_addr", a, 64'h8000_3000);
        chk("fetch_dropped_no_out", ov_cnt, m);

        // Redirect in HOLD with out_ready high
        wait_out();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        chk("hold_redir_valid", bus.out_valid, 1'b0);
        wait_req(a);
        chk("hold_redir_addr", a, 64'h8000_0100);

        // Misaligned PC and access fault
        wait_out();
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0102;
        tick();
        bus.redirect_valid = 1'b0;
        n = req_addr_log.size();
        wait_out();
        chk("mis_pc", bus.out_pc, 64'h8000_0102);
        chk("mis_inst", bus.out_inst, 32'h0);
        chk("mis_fault", bus.out_fault, 1'b1);
        chk("mis_no_req", req_addr_log.size(), n);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        wait_out();
        chk("mis_next_pc", bus.out_pc, 64'h8000_0106);
        chk("mis_next_fault", bus.out_fault, 1'b1);
        mem_err = 1'b1; mem_data = 32'h0010_0073;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_0200;
        tick();
        bus.redirect_valid = 1'b0;
        wait_out();
        mem_err = 1'b0; mem_data = 32'h0000_0013;
        chk("err_pc", bus.out_pc, 64'h8000_0200);
        chk("err_inst", bus.out_inst, 32'h0010_0073);
        chk("err_fault", bus.out_fault, 1'b1);

        // Reset while holding PC 0x8000000C
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_000C;
        tick();
        bus.redirect_valid = 1'b0;
        wait_out();
        chk("pre_rst_pc", bus.out_pc, 64'h8000_000C);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_valid", bus.out_valid, 1'b0);
        chk("post_rst_state", bus.dbg_state, 2'd0);
        wait_req(a);
        chk("post_rst_addr", a, 64'h8000_0000);

        // Mixed memory and decode back-pressure; the model checks every cycle
        for (int i = 0; i < 40; i++) begin
            bus.imem_req_ready = (i % 3) != 0;
            bus.out_ready      = (i % 4) != 1;
            tick();
        end
        bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
